// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store
// stage and a word-wide memory. Misses write back a dirty victim, then refill.
module dcache_controller #(
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_SETS        = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_busywait,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_busywait,
  output logic [1:0]            dbg_state_o
);

  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = ADDR_WIDTH - IW - OW - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [OW-1:0]       count_q;
  logic [TW-1:0]       miss_tag_q;
  logic [IW-1:0]       miss_idx_q;
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS][WORDS_PER_BLOCK];

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          req;
  logic          hit;
  logic          idle_hit;
  logic          last_word;

  assign req_off   = cpu_addr[OW+1:2];
  assign req_idx   = cpu_addr[OW+2 +: IW];
  assign req_tag   = cpu_addr[ADDR_WIDTH-1 -: TW];
  assign req       = cpu_read | cpu_write;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_hit  = (state_q == IDLE) && hit;
  assign last_word = (count_q == OW'(WORDS_PER_BLOCK - 1));

  assign cpu_busywait = req && !idle_hit;
  assign cpu_rdata    = (idle_hit && cpu_read) ? data_q[req_idx][req_off] : 32'h0;
  assign mem_read     = (state_q == ALLOCATE);
  assign mem_write    = (state_q == WRITEBACK);
  assign dbg_state_o  = state_q;

  // The miss index/tag are latched so a dropped or changed request cannot
  // redirect a block transfer that is already under way.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = 32'h0;
    case (state_q)
      WRITEBACK: begin
        mem_addr  = {tag_q[miss_idx_q], miss_idx_q, count_q, 2'b00};
        mem_wdata = data_q[miss_idx_q][count_q];
      end
      ALLOCATE: mem_addr = {miss_tag_q, miss_idx_q, count_q, 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      count_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (req && !hit) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            state_q    <= (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
          end else if (cpu_write && hit) begin
            dirty_q[req_idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            if (last_word) begin
              count_q <= '0;
              state_q <= ALLOCATE;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        ALLOCATE: begin
          if (!mem_busywait) begin
            if (last_word) begin
              count_q             <= '0;
              valid_q[miss_idx_q] <= 1'b1;
              dirty_q[miss_idx_q] <= 1'b0;
              state_q             <= IDLE;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (idle_hit && cpu_write) begin
      data_q[req_idx][req_off] <= cpu_wdata;
    end
    if ((state_q == ALLOCATE) && !mem_busywait) begin
      data_q[miss_idx_q][count_q] <= mem_rdata;
      if (last_word) begin
        tag_q[miss_idx_q] <= miss_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a word memory with programmable wait
// states, an expected-transfer queue, and table-driven hit vectors.
module tb_dcache_controller;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_rdata;
  logic        cpu_busywait;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_busywait;
  logic [1:0]  dbg_state;

  dcache_controller #(.ADDR_WIDTH(32), .NUM_SETS(8), .WORDS_PER_BLOCK(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_rdata    (cpu_rdata),
    .cpu_busywait (cpu_busywait),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .mem_busywait (mem_busywait),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  int          mem_waits;
  int          wait_cnt;
  logic        init_req;

  assign mem_rdata    = mem[mem_addr[11:2]];
  assign mem_busywait = (mem_read | mem_write) && (wait_cnt < mem_waits);

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (mem_read | mem_write) wait_cnt <= (wait_cnt < mem_waits) ? wait_cnt + 1 : 0;
    else wait_cnt <= 0;
  end

  // Word 0x10 (byte 0x40) holds 0xA5A5_0001; every other word w holds 0x1000_0000 + w.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= (i == 16) ? 32'hA5A5_0001 : 32'h1000_0000 + i;
    end else if (!reset && mem_write && !mem_busywait) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_fail;
  logic [64:0] exp_q[$];   // {is_write, byte address, write data (0 for reads)}
  logic        holding;
  logic [31:0] hold_addr;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_reads(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, base + 32'(4 * i), 32'h0});
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  // A transfer seen with busywait low at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      holding = 1'b0;
    end else if (mem_read | mem_write) begin
      if (holding) chk("mem_addr_hold", {64'h0, mem_addr}, {64'h0, hold_addr});
      chk("one_mem_req", {95'h0, mem_read & mem_write}, 96'h0);
      if (!mem_busywait) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mem_unexpected: got we=%0b addr=%0h, expected no transfer",
                   mem_write, mem_addr);
        end else begin
          chk("mem_xfer", {31'h0, mem_write, mem_addr, mem_write ? mem_wdata : 32'h0},
              {31'h0, exp_q.pop_front()});
        end
      end
      holding   = mem_busywait;
      hold_addr = mem_addr;
    end else begin
      holding = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the edge that retires the access.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                        input logic wr, output int busy, output logic [31:0] rdat);
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_read  = rd;
    cpu_write = wr;
    busy      = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!cpu_busywait) break;
      busy++;
    end
    rdat = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    int          exp_busy;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic apply_vecs(input int lo, input int hi);
    int          busy;
    logic [31:0] rdat;
    for (int i = lo; i <= hi; i++) begin
      access(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, busy, rdat);
      chk($sformatf("vec%0d_busy", i), 96'(busy), 96'(vecs[i].exp_busy));
      if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), {64'h0, rdat}, {64'h0, vecs[i].exp_rdata});
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int          busy;
    logic [31:0] rdat;

    vecs[0] = '{32'h44, 32'hDEADBEEF, 1'b0, 1'b1, 0, 32'h0};
    vecs[1] = '{32'h44, 32'h0,        1'b1, 1'b0, 0, 32'hDEADBEEF};
    vecs[2] = '{32'h40, 32'h11111111, 1'b0, 1'b1, 0, 32'h0};
    vecs[3] = '{32'h44, 32'h0,        1'b1, 1'b0, 0, 32'hDEADBEEF};
    vecs[4] = '{32'h44, 32'h22222222, 1'b0, 1'b1, 0, 32'h0};
    vecs[5] = '{32'h40, 32'h0,        1'b1, 1'b0, 0, 32'h11111111};
    vecs[6] = '{32'h40, 32'h33333333, 1'b0, 1'b1, 0, 32'h0};
    vecs[7] = '{32'h44, 32'h0,        1'b1, 1'b0, 0, 32'h22222222};
    vecs[8] = '{32'h44, 32'h44444444, 1'b0, 1'b1, 0, 32'h0};
    vecs[9] = '{32'h40, 32'h0,        1'b1, 1'b0, 0, 32'h33333333};

    n_cmp     = 0;
    n_fail    = 0;
    holding   = 1'b0;
    hold_addr = 32'h0;
    mem_waits = 0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    init_req  = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    chk("rst_busywait", {95'h0, cpu_busywait}, 96'h0);
    chk("rst_mem_read", {95'h0, mem_read}, 96'h0);
    chk("rst_mem_write", {95'h0, mem_write}, 96'h0);
    chk("rst_mem_addr", {64'h0, mem_addr}, 96'h0);
    chk("rst_mem_wdata", {64'h0, mem_wdata}, 96'h0);
    chk("rst_cpu_rdata", {64'h0, cpu_rdata}, 96'h0);
    chk("rst_state", {94'h0, dbg_state}, 96'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss on 0x40, then a hit elsewhere in the same line.
    push_reads(32'h40);
    access(32'h40, 32'h0, 1'b1, 1'b0, busy, rdat);
    chk("miss40_busy", 96'(busy), 96'd5);
    chk("miss40_rdata", {64'h0, rdat}, {64'h0, 32'hA5A5_0001});
    access(32'h48, 32'h0, 1'b1, 1'b0, busy, rdat);
    chk("hit48_busy", 96'(busy), 96'd0);
    chk("hit48_rdata", {64'h0, rdat}, {64'h0, 32'h1000_0012});
    chk("miss40_q_empty", 96'(exp_q.size()), 96'd0);

    // Store hit, read back.
    apply_vecs(0, 1);

    // Same index, new tag: dirty victim written back, then refill.
    push_write(32'h40, 32'hA5A5_0001);
    push_write(32'h44, 32'hDEADBEEF);
    push_write(32'h48, 32'h1000_0012);
    push_write(32'h4C, 32'h1000_0013);
    push_reads(32'h240);
    access(32'h240, 32'h0, 1'b1, 1'b0, busy, rdat);
    chk("dirty_busy", 96'(busy), 96'd9);
    chk("dirty_rdata", {64'h0, rdat}, {64'h0, 32'h1000_0090});
    chk("dirty_q_empty", 96'(exp_q.size()), 96'd0);

    // Three wait states per transfer on a clean miss.
    mem_waits = 3;
    push_reads(32'h100);
    access(32'h100, 32'h0, 1'b1, 1'b0, busy, rdat);
    chk("wait_busy", 96'(busy), 96'd17);
    chk("wait_rdata", {64'h0, rdat}, {64'h0, 32'h1000_0040});
    chk("wait_q_empty", 96'(exp_q.size()), 96'd0);

    // Reset during the second refill transfer.
    exp_q.push_back({1'b0, 32'h300, 32'h0});
    cpu_addr = 32'h300;
    cpu_read = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_state", {94'h0, dbg_state}, 96'd2);
    chk("mid_mem_addr", {64'h0, mem_addr}, {64'h0, 32'h304});
    reset    = 1'b1;
    cpu_read = 1'b0;
    #1;
    chk("arst_busywait", {95'h0, cpu_busywait}, 96'h0);
    chk("arst_mem_read", {95'h0, mem_read}, 96'h0);
    chk("arst_mem_addr", {64'h0, mem_addr}, 96'h0);
    chk("arst_cpu_rdata", {64'h0, cpu_rdata}, 96'h0);
    chk("arst_state", {94'h0, dbg_state}, 96'h0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_waits = 0;
    @(posedge clk);
    #1;
    push_reads(32'h300);
    access(32'h300, 32'h0, 1'b1, 1'b0, busy, rdat);
    chk("rerun_busy", 96'(busy), 96'd5);
    chk("rerun_rdata", {64'h0, rdat}, {64'h0, 32'h1000_00C0});
    chk("rerun_q_empty", 96'(exp_q.size()), 96'd0);

    // Lines were invalidated: refill 0x40 (memory holds the written-back block), then alternate hits.
    push_reads(32'h40);
    access(32'h40, 32'h0, 1'b1, 1'b0, busy, rdat);
    chk("refill40_busy", 96'(busy), 96'd5);
    chk("refill40_rdata", {64'h0, rdat}, {64'h0, 32'hA5A5_0001});
    apply_vecs(2, 9);
    chk("final_q_empty", 96'(exp_q.size()), 96'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
